// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates two register-file writeback requesters (ALU, load unit)
// onto a single registered write port. Each requester owns a one-entry buffer.
// Writes to the same register are issued oldest-first. Writes to different
// registers are arbitrated by a fixed or round-robin policy.
// Optional feature macro: WB_ARBITER_ROUND_ROBIN_EN. When it is defined,
// contested grants alternate between requesters. When it is undefined,
// requester 0 wins every contested grant and the round-robin pointer is absent.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_address,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_address,
  input  logic [31:0] req1_data,
  output logic        write_enable,
  output logic [4:0]  write_address,
  output logic [31:0] write_data,
  output logic [31:0] pending,
  output logic [15:0] stall_count
);

  // One-hot decode of a register address, gated by a valid flag.
  function automatic logic [31:0] f_onehot(input logic v, input logic [4:0] a);
    logic [31:0] res;
    if (v) begin
      res = 32'h0000_0001 << a;
    end else begin
      res = 32'h0000_0000;
    end
    return res;
  endfunction

  // Buffer state. r_bufN_old marks the buffer that was loaded strictly
  // earlier than the other valid buffer. When both buffers were loaded on the
  // same edge, neither bit is set and buf1 is treated as the older one.
  logic        r_buf0_valid;
  logic [4:0]  r_buf0_addr;
  logic [31:0] r_buf0_data;
  logic        r_buf0_old;
  logic        r_buf1_valid;
  logic [4:0]  r_buf1_addr;
  logic [31:0] r_buf1_data;
  logic        r_buf1_old;

  logic        r_we;
  logic [4:0]  r_wa;
  logic [31:0] r_wd;
  logic [31:0] r_pending;
  logic [15:0] r_stall_cnt;

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  // 0: requester 0 has priority on the next contested grant, 1: requester 1.
  logic        r_rr_ptr;
`endif

  logic        w_grant0;
  logic        w_grant1;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_load0;
  logic        w_load1;
  logic        w_keep0;
  logic        w_keep1;
  logic        w_stall;

  logic        w_nxt_buf0_valid;
  logic [4:0]  w_nxt_buf0_addr;
  logic [31:0] w_nxt_buf0_data;
  logic        w_nxt_buf0_old;
  logic        w_nxt_buf1_valid;
  logic [4:0]  w_nxt_buf1_addr;
  logic [31:0] w_nxt_buf1_data;
  logic        w_nxt_buf1_old;
  logic        w_nxt_we;
  logic [4:0]  w_nxt_wa;
  logic [31:0] w_nxt_wd;
  logic [31:0] w_nxt_pending;
  logic [15:0] w_nxt_stall_cnt;

  // Grant selection: oldest wins on a register conflict, otherwise the policy decides.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_buf0_valid && r_buf1_valid) begin
      if (r_buf0_addr == r_buf1_addr) begin
        if (r_buf0_old) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
      end else begin
`ifdef WB_ARBITER_ROUND_ROBIN_EN
        if (r_rr_ptr == 1'b0) begin
          w_grant0 = 1'b1;
        end else begin
          w_grant1 = 1'b1;
        end
`else
        w_grant0 = 1'b1;
`endif
      end
    end else if (r_buf0_valid) begin
      w_grant0 = 1'b1;
    end else if (r_buf1_valid) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
    end
  end

  // A buffer can accept a request when it is empty or it is being drained this cycle.
  assign w_ready0   = ~r_buf0_valid | w_grant0;
  assign w_ready1   = ~r_buf1_valid | w_grant1;
  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;

  // Writes to x0 complete the handshake but never occupy a buffer.
  assign w_load0 = req0_valid & w_ready0 & (req0_address != 5'd0);
  assign w_load1 = req1_valid & w_ready1 & (req1_address != 5'd0);
  assign w_keep0 = r_buf0_valid & ~w_grant0;
  assign w_keep1 = r_buf1_valid & ~w_grant1;
  assign w_stall = (req0_valid & ~w_ready0) | (req1_valid & ~w_ready1);

  // Next buffer contents and relative age.
  always_comb begin
    w_nxt_buf0_valid = w_load0 | w_keep0;
    w_nxt_buf1_valid = w_load1 | w_keep1;
    w_nxt_buf0_addr  = r_buf0_addr;
    w_nxt_buf0_data  = r_buf0_data;
    w_nxt_buf1_addr  = r_buf1_addr;
    w_nxt_buf1_data  = r_buf1_data;
    w_nxt_buf0_old   = r_buf0_old;
    w_nxt_buf1_old   = r_buf1_old;
    if (w_load0) begin
      w_nxt_buf0_addr = req0_address;
      w_nxt_buf0_data = req0_data;
    end else begin
      w_nxt_buf0_addr = r_buf0_addr;
      w_nxt_buf0_data = r_buf0_data;
    end
    if (w_load1) begin
      w_nxt_buf1_addr = req1_address;
      w_nxt_buf1_data = req1_data;
    end else begin
      w_nxt_buf1_addr = r_buf1_addr;
      w_nxt_buf1_data = r_buf1_data;
    end
    if (w_load0 && w_load1) begin
      w_nxt_buf0_old = 1'b0;
      w_nxt_buf1_old = 1'b0;
    end else if (w_load1 && w_keep0) begin
      w_nxt_buf0_old = 1'b1;
      w_nxt_buf1_old = 1'b0;
    end else if (w_load0 && w_keep1) begin
      w_nxt_buf0_old = 1'b0;
      w_nxt_buf1_old = 1'b1;
    end else begin
      w_nxt_buf0_old = r_buf0_old;
      w_nxt_buf1_old = r_buf1_old;
    end
  end

  // Next write port drive: address and data hold when nothing is granted.
  always_comb begin
    w_nxt_we = w_grant0 | w_grant1;
    w_nxt_wa = r_wa;
    w_nxt_wd = r_wd;
    if (w_grant0) begin
      w_nxt_wa = r_buf0_addr;
      w_nxt_wd = r_buf0_data;
    end else if (w_grant1) begin
      w_nxt_wa = r_buf1_addr;
      w_nxt_wd = r_buf1_data;
    end else begin
      w_nxt_wa = r_wa;
      w_nxt_wd = r_wd;
    end
  end

  // Next pending map and saturating stall counter.
  always_comb begin
    w_nxt_pending = (f_onehot(w_nxt_buf0_valid, w_nxt_buf0_addr)
                   | f_onehot(w_nxt_buf1_valid, w_nxt_buf1_addr)
                   | f_onehot(w_nxt_we, w_nxt_wa)) & ~32'h0000_0001;
    if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      w_nxt_stall_cnt = r_stall_cnt + 16'd1;
    end else begin
      w_nxt_stall_cnt = r_stall_cnt;
    end
  end

  // State update; reset drops any buffered writes without issuing them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0_valid <= 1'b0;
      r_buf0_addr  <= 5'd0;
      r_buf0_data  <= 32'd0;
      r_buf0_old   <= 1'b0;
      r_buf1_valid <= 1'b0;
      r_buf1_addr  <= 5'd0;
      r_buf1_data  <= 32'd0;
      r_buf1_old   <= 1'b0;
      r_we         <= 1'b0;
      r_wa         <= 5'd0;
      r_wd         <= 32'd0;
      r_pending    <= 32'd0;
      r_stall_cnt  <= 16'd0;
    end else begin
      r_buf0_valid <= w_nxt_buf0_valid;
      r_buf0_addr  <= w_nxt_buf0_addr;
      r_buf0_data  <= w_nxt_buf0_data;
      r_buf0_old   <= w_nxt_buf0_old;
      r_buf1_valid <= w_nxt_buf1_valid;
      r_buf1_addr  <= w_nxt_buf1_addr;
      r_buf1_data  <= w_nxt_buf1_data;
      r_buf1_old   <= w_nxt_buf1_old;
      r_we         <= w_nxt_we;
      r_wa         <= w_nxt_wa;
      r_wd         <= w_nxt_wd;
      r_pending    <= w_nxt_pending;
      r_stall_cnt  <= w_nxt_stall_cnt;
    end
  end

`ifdef WB_ARBITER_ROUND_ROBIN_EN
  // After a contested grant, priority moves to the requester that lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (r_buf0_valid && r_buf1_valid) begin
      r_rr_ptr <= w_grant0;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  assign write_enable  = r_we;
  assign write_address = r_wa;
  assign write_data    = r_wd;
  assign pending       = r_pending;
  assign stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter. It compares the outputs on every cycle
// against a behavioural model that tracks load order with edge numbers, and it
// adds directed literal checks.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [4:0]  req0_address = 5'd0;
  logic [31:0] req0_data = 32'd0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [4:0]  req1_address = 5'd0;
  logic [31:0] req1_data = 32'd0;
  logic        write_enable;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [31:0] pending;
  logic [15:0] stall_count;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_address(req0_address), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_address(req1_address), .req1_data(req1_data),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .pending(pending), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: each buffer records the edge number at which it was loaded.
  bit          m_v[2];
  logic [4:0]  m_a[2];
  logic [31:0] m_d[2];
  int          m_seq[2];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_stall;
  int          m_edge;
  int          m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (m_v[0] && m_v[1]) begin
      if (m_a[0] == m_a[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
`ifdef WB_ARBITER_ROUND_ROBIN_EN
      return m_ptr;
`else
      return 0;
`endif
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_a[i] = 5'd0; m_d[i] = 32'd0; m_seq[i] = 0;
    end
    m_we = 1'b0; m_wa = 5'd0; m_wd = 32'd0; m_stall = 0; m_edge = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    int g;
    bit rdy0, rdy1;
    g = model_grant();
    rdy0 = !m_v[0] || g == 0;
    rdy1 = !m_v[1] || g == 1;
    if (((req0_valid && !rdy0) || (req1_valid && !rdy1)) && m_stall < 65535) m_stall++;
    if (g >= 0) begin
      if (m_v[0] && m_v[1]) m_ptr = 1 - g;
      m_we = 1'b1; m_wa = m_a[g]; m_wd = m_d[g]; m_v[g] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    m_edge++;
    if (req0_valid && rdy0 && req0_address != 5'd0) begin
      m_v[0] = 1'b1; m_a[0] = req0_address; m_d[0] = req0_data; m_seq[0] = m_edge;
    end
    if (req1_valid && rdy1 && req1_address != 5'd0) begin
      m_v[1] = 1'b1; m_a[1] = req1_address; m_d[1] = req1_data; m_seq[1] = m_edge;
    end
  endtask

  // Model update at each clock edge or asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    int g;
    logic [31:0] pend;
    forever begin
      @(negedge clk);
      if (!rst) begin
        g = model_grant();
        pend = 32'd0;
        for (int i = 0; i < 2; i++) if (m_v[i]) pend = pend | (32'd1 << m_a[i]);
        if (m_we) pend = pend | (32'd1 << m_wa);
        pend[0] = 1'b0;
        chk("ready0", {31'd0, req0_ready}, {31'd0, (!m_v[0] || g == 0)});
        chk("ready1", {31'd0, req1_ready}, {31'd0, (!m_v[1] || g == 1)});
        chk("we", {31'd0, write_enable}, {31'd0, m_we});
        chk("waddr", {27'd0, write_address}, {27'd0, m_wa});
        chk("wdata", write_data, m_wd);
        chk("pending", pending, pend);
        chk("stall", {16'd0, stall_count}, m_stall);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    logic [4:0] a;
    if ($urandom_range(0, 3) != 0) a = 5'($urandom_range(0, 3));
    else a = 5'($urandom_range(0, 31));
    return a;
  endfunction

  // Directed and random stimulus with literal expectations.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_we", {31'd0, write_enable}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_stall", {16'd0, stall_count}, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd1);

    // Single req0 transfer to x5.
    tick();
    req0_valid = 1'b1; req0_address = 5'd5; req0_data = 32'hDEADBEEF;
    tick();
    req0_valid = 1'b0;
    chk("s_c1_pending", pending, 32'h0000_0020);
    chk("s_c1_we", {31'd0, write_enable}, 32'd0);
    tick();
    chk("s_c2_we", {31'd0, write_enable}, 32'd1);
    chk("s_c2_addr", {27'd0, write_address}, 32'd5);
    chk("s_c2_data", write_data, 32'hDEADBEEF);
    chk("s_c2_pending", pending, 32'h0000_0020);
    tick();
    chk("s_c3_we", {31'd0, write_enable}, 32'd0);
    chk("s_c3_pending", pending, 32'd0);

    // Same-edge conflict on x7: buf1 first.
    tick();
    req0_valid = 1'b1; req0_address = 5'd7; req0_data = 32'h1;
    req1_valid = 1'b1; req1_address = 5'd7; req1_data = 32'h2;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("c_first_data", write_data, 32'h2);
    chk("c_first_we", {31'd0, write_enable}, 32'd1);
    tick();
    chk("c_second_data", write_data, 32'h1);
    chk("c_second_addr", {27'd0, write_address}, 32'd7);
    tick();
    chk("c_done_we", {31'd0, write_enable}, 32'd0);

    // Write to x0 is discarded.
    tick();
    req1_valid = 1'b1; req1_address = 5'd0; req1_data = 32'hFFFFFFFF;
    chk("x0_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("x0_c1_pending", pending, 32'd0);
    chk("x0_c1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    chk("x0_c2_we", {31'd0, write_enable}, 32'd0);
    chk("x0_c2_pending", pending, 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_address = rand_addr();
      req0_data = $urandom;
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_address = rand_addr();
      req1_data = $urandom;
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Reset pulse between edges with both buffers loaded.
    req0_valid = 1'b1; req0_address = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_address = 5'd4; req1_data = 32'h44;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("r_pre_pending", pending, 32'h0000_0018);
    #1 rst = 1'b1;
    #1;
    chk("r_we", {31'd0, write_enable}, 32'd0);
    chk("r_addr", {27'd0, write_address}, 32'd0);
    chk("r_data", write_data, 32'd0);
    chk("r_pending", pending, 32'd0);
    chk("r_stall", {16'd0, stall_count}, 32'd0);
    rst = 1'b0;
    tick();
    chk("r_post_we", {31'd0, write_enable}, 32'd0);
    chk("r_post_ready0", {31'd0, req0_ready}, 32'd1);
    chk("r_post_ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    chk("r_post2_we", {31'd0, write_enable}, 32'd0);

    // Continuous traffic on both ports: x1 from req0, x2 from req1.
    req0_valid = 1'b1; req0_address = 5'd1; req0_data = 32'hA1;
    req1_valid = 1'b1; req1_address = 5'd2; req1_data = 32'hB2;
    tick();
    chk("b_c1_ready0", {31'd0, req0_ready}, 32'd1);
    chk("b_c1_ready1", {31'd0, req1_ready}, 32'd0);
    chk("b_c1_stall", {16'd0, stall_count}, 32'd0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk("b_stall", {16'd0, stall_count}, c - 1);
`ifdef WB_ARBITER_ROUND_ROBIN_EN
      chk("b_addr", {27'd0, write_address}, (c % 2 == 0) ? 32'd1 : 32'd2);
`else
      chk("b_addr", {27'd0, write_address}, 32'd1);
      chk("b_ready1", {31'd0, req1_ready}, 32'd0);
`endif
    end
    repeat (65600) tick();
    chk("b_sat", {16'd0, stall_count}, 32'h0000_FFFF);
`ifndef WB_ARBITER_ROUND_ROBIN_EN
    chk("b_req1_starved", {27'd0, write_address}, 32'd1);
`endif
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
